// File: rtl/pe_seq_pkg.sv
// Shared types and defaults for the PE cluster job sequencer.
package pe_seq_pkg;

    // Sequencer states; 3-bit encoding covers all eight.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_LOAD_A  = 3'd2,
        S_COMPUTE = 3'd3,
        S_DRAIN   = 3'd4,
        S_OUT     = 3'd5,
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } seq_state_t;

    localparam int DEF_DATA_BITWIDTH = 16;
    localparam int DEF_X_DIM         = 5;
    localparam int DEF_DRAIN_CYCLES  = 1;
    localparam int DEF_TIMEOUT       = 1023;
    localparam int PSUM_BUS_W        = DEF_DATA_BITWIDTH * DEF_X_DIM;

    // States in which the sequencer waits on a cluster handshake.
    function automatic logic is_wait_state(input seq_state_t s);
        return (s == S_LOAD_W) || (s == S_LOAD_A) || (s == S_COMPUTE);
    endfunction

endpackage

// File: rtl/pe_seq_watchdog.sv
// Wait-cycle watchdog: counts cycles while enabled, expires after TIMEOUT cycles.
module pe_seq_watchdog
    import pe_seq_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TO_W    = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TO_W-1:0] count_reg;

    // Count wait cycles; restart on any state change or outside wait states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear || !enable) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // The cycle holding count TIMEOUT-1 is the TIMEOUT-th wait cycle.
    assign expire = enable && (count_reg == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/pe_cluster_seq.sv
// Job sequencer for one PE cluster: weight load, per-pass activation load,
// compute, drain and valid/ready hand-off of the column psums.
module pe_cluster_seq
    import pe_seq_pkg::*;
#(
    parameter int DATA_BITWIDTH = DEF_DATA_BITWIDTH,
    parameter int X_dim         = DEF_X_DIM,
    parameter int PASS_W        = 8,
    parameter int DRAIN_CYCLES  = DEF_DRAIN_CYCLES,
    parameter int TIMEOUT       = DEF_TIMEOUT,
    parameter int TO_W          = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           job_start,
    input  logic [PASS_W-1:0]              num_passes,
    output logic                           busy,
    output logic                           job_done,
    output logic                           error,
    output logic [PASS_W-1:0]              pass_idx,
    output logic                           load_en_wght,
    output logic                           load_en_act,
    output logic                           pe_start,
    input  logic                           load_done,
    input  logic                           compute_done,
    input  logic [DATA_BITWIDTH*X_dim-1:0] pe_out_in,
    output logic [DATA_BITWIDTH*X_dim-1:0] psum_data,
    output logic                           psum_valid,
    input  logic                           psum_ready
);

    localparam int BUS_W = DATA_BITWIDTH * X_dim;
    localparam int DRN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    seq_state_t        state_reg, state_next;
    logic [PASS_W-1:0] num_passes_reg, num_passes_next;
    logic [PASS_W-1:0] pass_idx_reg, pass_idx_next;
    logic [DRN_W-1:0]  drain_cnt_reg, drain_cnt_next;
    logic [BUS_W-1:0]  psum_data_reg, psum_data_next;
    logic              error_reg, error_next;
    logic              busy_reg, job_done_reg, load_en_wght_reg, load_en_act_reg;
    logic              pe_start_reg, psum_valid_reg;
    logic              wd_expire;

    pe_seq_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_next != state_reg),
        .enable (is_wait_state(state_reg)),
        .expire (wd_expire)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, pass/drain counters and psum capture.
    always_comb begin
        state_next      = state_reg;
        num_passes_next = num_passes_reg;
        pass_idx_next   = pass_idx_reg;
        drain_cnt_next  = drain_cnt_reg;
        psum_data_next  = psum_data_reg;
        error_next      = error_reg;
        case (state_reg)
            S_IDLE: begin
                if (job_start) begin
                    error_next      = 1'b0;
                    pass_idx_next   = '0;
                    num_passes_next = num_passes;
                    state_next      = (num_passes != '0) ? S_LOAD_W : S_DONE;
                end
            end
            S_LOAD_W: begin
                if (load_done)      state_next = S_LOAD_A;
                else if (wd_expire) state_next = S_ERR;
            end
            S_LOAD_A: begin
                if (load_done)      state_next = S_COMPUTE;
                else if (wd_expire) state_next = S_ERR;
            end
            S_COMPUTE: begin
                if (compute_done) begin
                    state_next     = S_DRAIN;
                    drain_cnt_next = DRN_W'(DRAIN_CYCLES);
                end else if (wd_expire) begin
                    state_next = S_ERR;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_reg == '0) begin
                    psum_data_next = pe_out_in;
                    state_next     = S_OUT;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 1'b1;
                end
            end
            S_OUT: begin
                if (psum_valid_reg && psum_ready) begin
                    if (pass_idx_reg == num_passes_reg - PASS_W'(1)) begin
                        state_next = S_DONE;
                    end else begin
                        pass_idx_next = pass_idx_reg + 1'b1;
                        state_next    = S_LOAD_A;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (state_next == S_ERR) begin
            error_next = 1'b1;
        end
    end

    // Datapath and output registers; outputs decode the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_passes_reg   <= '0;
            pass_idx_reg     <= '0;
            drain_cnt_reg    <= '0;
            psum_data_reg    <= '0;
            error_reg        <= 1'b0;
            busy_reg         <= 1'b0;
            job_done_reg     <= 1'b0;
            load_en_wght_reg <= 1'b0;
            load_en_act_reg  <= 1'b0;
            pe_start_reg     <= 1'b0;
            psum_valid_reg   <= 1'b0;
        end else begin
            num_passes_reg   <= num_passes_next;
            pass_idx_reg     <= pass_idx_next;
            drain_cnt_reg    <= drain_cnt_next;
            psum_data_reg    <= psum_data_next;
            error_reg        <= error_next;
            busy_reg         <= (state_next != S_IDLE) && (state_next != S_ERR);
            job_done_reg     <= (state_next == S_DONE);
            load_en_wght_reg <= (state_next == S_LOAD_W);
            load_en_act_reg  <= (state_next == S_LOAD_A);
            pe_start_reg     <= (state_next == S_COMPUTE) && (state_reg != S_COMPUTE);
            psum_valid_reg   <= (state_next == S_OUT);
        end
    end

    assign busy         = busy_reg;
    assign job_done     = job_done_reg;
    assign error        = error_reg;
    assign pass_idx     = pass_idx_reg;
    assign load_en_wght = load_en_wght_reg;
    assign load_en_act  = load_en_act_reg;
    assign pe_start     = pe_start_reg;
    assign psum_data    = psum_data_reg;
    assign psum_valid   = psum_valid_reg;

endmodule

// File: doc/pe_cluster_seq.md
Name: pe_cluster_seq

Overview:
Job sequencer for one PE cluster. It drives the cluster's load_en_wght, load_en_act and start controls and loads weights once per job. For each pass it reloads activations, triggers compute, drains the registered column psums, and hands them downstream over a valid/ready port. A watchdog flags any cluster handshake that hangs.

Parameters:
DATA_BITWIDTH, 16, width of one column psum
X_dim, 5, number of cluster columns (psum lanes)
PASS_W, 8, width of pass count/index
DRAIN_CYCLES, 1, cycles from compute_done until the cluster pe_out is final
TIMEOUT, 1023, maximum wait cycles in any LOAD_*/COMPUTE state before error
TO_W, 10, watchdog counter width (must hold TIMEOUT)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
job_start  in  1  single-cycle job request; ignored while busy=1
num_passes  in  PASS_W  passes in the job; sampled when job_start is accepted
busy  out  1  high from the cycle after acceptance until DONE exits
job_done  out  1  one-cycle pulse when the final pass is handed off
error  out  1  sticky watchdog flag; cleared by reset or an accepted job_start
pass_idx  out  PASS_W  index of the current pass
load_en_wght  out  1  to cluster load_en_wght
load_en_act  out  1  to cluster load_en_act
pe_start  out  1  to cluster start; one-cycle pulse
load_done  in  1  from cluster
compute_done  in  1  from cluster
pe_out_in  in  DATA_BITWIDTH*X_dim  cluster pe_out bus
psum_data  out  DATA_BITWIDTH*X_dim  captured psums, held stable while psum_valid=1
psum_valid  out  1  psum_data is valid
psum_ready  in  1  downstream accepts

Behaviour:
- All outputs are registered. Reset (asynchronous) forces state=IDLE and sets every output to 0, including psum_data and pass_idx.
- Reset mid-job aborts immediately. No partial output is held after reset.
- States: IDLE, LOAD_W, LOAD_A, COMPUTE, DRAIN, OUT, DONE, ERR.
- IDLE: on job_start with num_passes>0, latch num_passes, clear error and pass_idx, go to LOAD_W. load_en_wght and busy are 1 the next cycle.
- IDLE, num_passes=0: go straight to DONE. No cluster control is asserted.
- LOAD_W: hold load_en_wght=1. When load_done=1, go to LOAD_A; load_en_wght=0 and load_en_act=1 the next cycle.
- LOAD_A: hold load_en_act=1. When load_done=1, go to COMPUTE; pe_start=1 for exactly the entry cycle.
- COMPUTE: when compute_done=1, go to DRAIN and load the drain counter with DRAIN_CYCLES.
- DRAIN: decrement the counter. At 0, capture pe_out_in into psum_data, set psum_valid=1 and go to OUT.
- DRAIN with DRAIN_CYCLES=0: capture occurs in the first DRAIN cycle.
- OUT: hold psum_valid and psum_data until psum_valid and psum_ready are both 1. Then:
  - if pass_idx==num_passes-1, go to DONE;
  - otherwise increment pass_idx and go to LOAD_A (weights are not reloaded).
- OUT: if psum_ready is already 1 on the cycle valid rises, the transfer completes in that cycle.
- DONE: job_done=1 for one cycle, busy=0 next cycle, return to IDLE. A job_start in the DONE cycle is ignored.
- load_done/compute_done arriving in a state that does not wait for them are ignored. Only the first high cycle in the waiting state counts.
- Watchdog: counts cycles in LOAD_W, LOAD_A and COMPUTE, and resets on every state change.
- Watchdog expiry: on reaching TIMEOUT, go to ERR. error=1, all cluster enables=0, psum_valid=0, busy=0. ERR goes to IDLE the next cycle and error stays 1.
- pass_idx wraps only via a new job; it never exceeds num_passes-1.

Decomposition:
- Package pe_seq_pkg holds:
  - the state enum (8 states, 3-bit encoding);
  - default constants for DRAIN_CYCLES and TIMEOUT;
  - a localparam for the psum bus width (DATA_BITWIDTH*X_dim).
- One sub-module, pe_seq_watchdog: a TO_W-bit counter with clear/enable inputs and an expire output. The main module holds the FSM, pass counter, drain counter and output register.

Test Plan:
- Single pass: job_start, num_passes=1; cluster model raises load_done 4 cycles after each load enable and compute_done 10 cycles after pe_start; pe_out_in lanes = {5,4,3,2,1} after drain; psum_ready=1 → exactly one pe_start, psum_data={5,4,3,2,1}, job_done pulse, load_en_wght high exactly once.
- Three passes: num_passes=3, same cluster model → load_en_wght asserted once, load_en_act three times, pass_idx 0→1→2, three psum handshakes, job_done after the third.
- Backpressure: psum_ready held low 7 cycles in OUT → psum_valid and psum_data stable for all 7 cycles; advances in the cycle psum_ready rises.
- Timeout: TIMEOUT=20, cluster never asserts load_done → ERR after 20 wait cycles, error=1, enables=0; next job_start clears error and the job completes normally.
- Reset mid-compute: async reset asserted between clock edges during COMPUTE → all outputs 0 immediately; a stray compute_done after reset is ignored and the FSM stays IDLE.
- Corner cases:
  - num_passes=0 → job_done on the second cycle, no cluster enables asserted;
  - job_start while busy → ignored;
  - compute_done pulsed during LOAD_A → ignored.
